// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame scheduler.
package cam_pkg;

    typedef enum logic [2:0] {
        S_WAIT_CFG,
        S_IDLE,
        S_ARMED,
        S_SYNC,
        S_CAPTURE,
        S_COMMIT
    } sched_state_t;

    localparam int CAM_H_ACT = 640;
    localparam int CAM_V_ACT = 480;

    function automatic int frame_pixels(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/cam_frame_sched_bank_swap.sv
// Ping-pong bank ownership: tracks back/front bank and whether the reader has released the front bank.
module cam_bank_swap (
    input  logic pclk,
    input  logic reset,
    input  logic commit_req,
    input  logic rd_done,
    output logic wr_bank,
    output logic front_bank,
    output logic swap_ok,
    output logic frame_ready
);

    logic front_free_reg;

    // A release arriving in the commit cycle counts as already applied.
    assign swap_ok = commit_req && (front_free_reg || rd_done);

    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_bank        <= 1'b1;
            front_bank     <= 1'b0;
            front_free_reg <= 1'b1;
            frame_ready    <= 1'b0;
        end else begin
            frame_ready <= swap_ok;
            if (swap_ok) begin
                front_bank     <= wr_bank;
                wr_bank        <= ~wr_bank;
                front_free_reg <= 1'b0;
            end else if (rd_done) begin
                front_free_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_frame_sched.sv
// Frame capture scheduler for a ping-pong frame buffer.
// Define CAM_SCHED_STATS_EN to add frames_committed / frames_dropped counters.
module cam_frame_sched
    import cam_pkg::*;
#(
    parameter int H_ACT  = CAM_H_ACT,
    parameter int V_ACT  = CAM_V_ACT,
    parameter int ADDR_W = 19
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              config_done,
    input  logic              vsync,
    input  logic              pix_valid,
    input  logic [7:0]        pix_in,
    input  logic              continuous,
    input  logic              start_req,
    input  logic              rd_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_bank,
    output logic              front_bank,
    output logic              frame_ready,
    output logic              busy,
    output logic              err_short,
    output logic              err_over
`ifdef CAM_SCHED_STATS_EN
    ,
    output logic [15:0]       frames_committed,
    output logic [15:0]       frames_dropped
`endif
);

    localparam logic [ADDR_W-1:0] FULL = ADDR_W'(frame_pixels(H_ACT, V_ACT));

    sched_state_t      state_reg;
    sched_state_t      state_next;
    logic              vsync_q;
    logic [ADDR_W-1:0] count_reg;
    logic              frame_start;
    logic              frame_end;
    logic              count_full;
    logic              in_sync;
    logic              in_capture;
    logic              in_commit;
    logic              commit_req;
    logic              swap_ok;

    assign frame_start = vsync_q && !vsync;
    assign frame_end   = vsync && !vsync_q;
    assign count_full  = (count_reg == FULL);

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg <= S_WAIT_CFG;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!config_done) begin
            state_next = S_WAIT_CFG;
        end else begin
            case (state_reg)
                S_WAIT_CFG: state_next = S_IDLE;
                S_IDLE:     if (continuous || start_req) state_next = S_ARMED;
                S_ARMED:    if (vsync) state_next = S_SYNC;
                S_SYNC:     if (frame_start) state_next = S_CAPTURE;
                S_CAPTURE:  if (frame_end) state_next = S_COMMIT;
                S_COMMIT:   state_next = continuous ? S_ARMED : S_IDLE;
                default:    state_next = S_WAIT_CFG;
            endcase
        end
    end

    always_comb begin
        in_sync    = (state_reg == S_SYNC);
        in_capture = (state_reg == S_CAPTURE);
        in_commit  = (state_reg == S_COMMIT);
        busy       = in_sync || in_capture;
    end

    // Losing config_done during the commit cycle abandons the frame.
    assign commit_req = in_commit && config_done && count_full;

    always_ff @(posedge pclk) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            count_reg <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err_short <= 1'b0;
            err_over  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            wr_en   <= 1'b0;
            if (in_sync && frame_start) begin
                count_reg <= '0;
            end
            if (in_capture && pix_valid) begin
                if (!count_full) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= count_reg;
                    wr_data   <= pix_in;
                    count_reg <= count_reg + 1'b1;
                end else begin
                    err_over <= 1'b1;
                end
            end
            if (in_commit && config_done && !count_full) begin
                err_short <= 1'b1;
            end
        end
    end

    cam_bank_swap u_bank_swap (
        .pclk        (pclk),
        .reset       (reset),
        .commit_req  (commit_req),
        .rd_done     (rd_done),
        .wr_bank     (wr_bank),
        .front_bank  (front_bank),
        .swap_ok     (swap_ok),
        .frame_ready (frame_ready)
    );

`ifdef CAM_SCHED_STATS_EN
    always_ff @(posedge pclk) begin
        if (reset) begin
            frames_committed <= '0;
            frames_dropped   <= '0;
        end else begin
            if (swap_ok) begin
                frames_committed <= frames_committed + 16'd1;
            end
            if (commit_req && !swap_ok && frames_dropped != 16'hFFFF) begin
                frames_dropped <= frames_dropped + 16'd1;
            end
        end
    end
`else
    logic stats_unused;
    assign stats_unused = swap_ok;
`endif

endmodule

// File: tb/tb_cam_frame_sched.sv
// Directed bench for cam_frame_sched with a 4x2 frame.
module tb_cam_frame_sched;
    import cam_pkg::*;

    localparam int AW   = 4;
    localparam int NPIX = 8;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          config_done = 1'b0;
    logic          vsync = 1'b1;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_in = 8'h00;
    logic          continuous = 1'b0;
    logic          start_req = 1'b0;
    logic          rd_done = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_bank;
    logic          front_bank;
    logic          frame_ready;
    logic          busy;
    logic          err_short;
    logic          err_over;
`ifdef CAM_SCHED_STATS_EN
    logic [15:0]   frames_committed;
    logic [15:0]   frames_dropped;
`endif

    int checks = 0;
    int failures = 0;
    int cycle_cnt = 0;
    int rise_cycle[$];
    logic [12:0] wq[$];
    int fr_cycle[$];
    logic fr_front[$];

    cam_frame_sched #(.H_ACT(4), .V_ACT(2), .ADDR_W(AW)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .config_done (config_done),
        .vsync       (vsync),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .continuous  (continuous),
        .start_req   (start_req),
        .rd_done     (rd_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_bank     (wr_bank),
        .front_bank  (front_bank),
        .frame_ready (frame_ready),
        .busy        (busy),
        .err_short   (err_short),
        .err_over    (err_over)
`ifdef CAM_SCHED_STATS_EN
        ,
        .frames_committed (frames_committed),
        .frames_dropped   (frames_dropped)
`endif
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge pclk) begin
        if (!reset && wr_en) wq.push_back({wr_bank, wr_addr, wr_data});
        if (!reset && frame_ready) begin
            fr_cycle.push_back(cycle_cnt);
            fr_front.push_back(front_bank);
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset(input logic cont);
        reset = 1'b1; config_done = 1'b1; continuous = cont; vsync = 1'b1;
        pix_valid = 1'b0; start_req = 1'b0; rd_done = 1'b0; pix_in = 8'h00;
        step(); step();
        reset = 1'b0;
        wq.delete(); fr_cycle.delete(); fr_front.delete(); rise_cycle.delete();
    endtask

    task automatic blank(input int k, input bit rd_at_commit);
        if (!vsync) rise_cycle.push_back(cycle_cnt);
        vsync = 1'b1;
        for (int i = 0; i < k; i++) begin
            step();
            rd_done = rd_at_commit && (i == 0);
        end
        rd_done = 1'b0;
    endtask

    task automatic active(input int n, input logic [7:0] d0, input int rd_at, input int start_at);
        vsync = 1'b0;
        step(); step();
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1; pix_in = d0 + 8'(i);
            rd_done = (i == rd_at); start_req = (i == start_at);
            step();
            pix_valid = 1'b0; rd_done = 1'b0; start_req = 1'b0;
            step();
        end
        step(); step();
    endtask

    task automatic test_reset();
        reset = 1'b1; config_done = 1'b1; vsync = 1'b1;
        step(); step();
        checks++;
        if ({wr_en, wr_addr, wr_data, wr_bank, front_bank, frame_ready, busy, err_short, err_over}
            !== {1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_outputs: got %b required %b",
                {wr_en, wr_addr, wr_data, wr_bank, front_bank, frame_ready, busy, err_short, err_over},
                {1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'b0000});
        end
        checks++;
        if (dut.state_reg !== S_WAIT_CFG) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", dut.state_reg, S_WAIT_CFG);
        end
    endtask

    task automatic test_latency();
        do_reset(1'b1);
        blank(5, 1'b0);
        vsync = 1'b0;
        step(); step();
        pix_valid = 1'b1; pix_in = 8'hAB;
        step();
        pix_valid = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'd0, 8'hAB, 1'b1}) begin
            failures++;
            $display("FAIL latency_write: got %h required %h", {wr_en, wr_addr, wr_data, busy},
                {1'b1, 4'd0, 8'hAB, 1'b1});
        end
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL latency_strobe: got wr_en=%b required 0", wr_en);
        end
    endtask

    task automatic test_continuous();
        logic [12:0] exp_w;
        do_reset(1'b1);
        blank(5, 1'b0); active(NPIX, 8'h10, -1, -1);
        blank(5, 1'b0); active(NPIX, 8'h20, 3, -1);
        blank(5, 1'b0);
        checks++;
        if (wq.size() != 16) begin
            failures++;
            $display("FAIL cont_write_count: got %0d required 16", wq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_w = (i < 8) ? {1'b1, AW'(i), 8'h10 + 8'(i)} : {1'b0, AW'(i - 8), 8'h20 + 8'(i - 8)};
                checks++;
                if (wq[i] !== exp_w) begin
                    failures++;
                    $display("FAIL cont_write[%0d]: got %h required %h", i, wq[i], exp_w);
                end
            end
        end
        checks++;
        if (fr_cycle.size() != 2 || rise_cycle.size() < 2) begin
            failures++;
            $display("FAIL cont_ready_count: got %0d required 2", fr_cycle.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (fr_cycle[k] != rise_cycle[k] + 2) begin
                    failures++;
                    $display("FAIL cont_ready_latency[%0d]: got %0d required %0d", k,
                        fr_cycle[k] - rise_cycle[k], 2);
                end
                checks++;
                if (fr_front[k] !== ((k == 0) ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL cont_front[%0d]: got %b required %b", k, fr_front[k], (k == 0));
                end
            end
        end
    endtask

    task automatic test_single_shot();
        logic [12:0] exp_w;
        do_reset(1'b0);
        blank(5, 1'b0);
        active(NPIX, 8'h80, -1, 2);
        blank(5, 1'b0); active(NPIX, 8'h30, -1, -1);
        blank(5, 1'b0); active(NPIX, 8'h50, -1, -1);
        blank(5, 1'b0);
        checks++;
        if (wq.size() != 8) begin
            failures++;
            $display("FAIL single_write_count: got %0d required 8", wq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_w = {1'b1, AW'(i), 8'h30 + 8'(i)};
                checks++;
                if (wq[i] !== exp_w) begin
                    failures++;
                    $display("FAIL single_write[%0d]: got %h required %h", i, wq[i], exp_w);
                end
            end
        end
        checks++;
        if (fr_cycle.size() != 1) begin
            failures++;
            $display("FAIL single_ready_count: got %0d required 1", fr_cycle.size());
        end
        checks++;
        if (dut.state_reg !== S_IDLE || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got state=%0d busy=%b required state=%0d busy=0",
                dut.state_reg, busy, S_IDLE);
        end
    endtask

    task automatic test_reader_slow();
        do_reset(1'b1);
        blank(5, 1'b0); active(NPIX, 8'h10, -1, -1);
        blank(5, 1'b0); active(NPIX, 8'h20, -1, -1);
        blank(5, 1'b0);
        checks++;
        if ({fr_cycle.size() == 1, front_bank, wr_bank} !== 3'b110) begin
            failures++;
            $display("FAIL slow_drop: got ready=%0d front=%b wr=%b required ready=1 front=1 wr=0",
                fr_cycle.size(), front_bank, wr_bank);
        end
        active(NPIX, 8'h40, 2, -1);
        blank(5, 1'b0);
        checks++;
        if ({fr_cycle.size() == 2, front_bank, wr_bank} !== 3'b101) begin
            failures++;
            $display("FAIL slow_commit: got ready=%0d front=%b wr=%b required ready=2 front=0 wr=1",
                fr_cycle.size(), front_bank, wr_bank);
        end
        checks++;
        if (wq.size() != 24) begin
            failures++;
            $display("FAIL slow_write_count: got %0d required 24", wq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wq[16 + i] !== {1'b0, AW'(i), 8'h40 + 8'(i)}) begin
                    failures++;
                    $display("FAIL slow_write[%0d]: got %h required %h", 16 + i, wq[16 + i],
                        {1'b0, AW'(i), 8'h40 + 8'(i)});
                end
            end
        end
`ifdef CAM_SCHED_STATS_EN
        checks++;
        if (frames_dropped !== 16'd1 || frames_committed !== 16'd2) begin
            failures++;
            $display("FAIL slow_stats: got dropped=%0d committed=%0d required 1 and 2",
                frames_dropped, frames_committed);
        end
`endif
    endtask

    task automatic test_short_long();
        do_reset(1'b1);
        blank(5, 1'b0); active(5, 8'h60, -1, -1);
        blank(5, 1'b0);
        checks++;
        if ({err_short, err_over, front_bank, wr_bank, fr_cycle.size() == 0} !== 5'b10011) begin
            failures++;
            $display("FAIL short_frame: got short=%b over=%b front=%b wr=%b ready=%0d required 1 0 0 1 0",
                err_short, err_over, front_bank, wr_bank, fr_cycle.size());
        end
        active(10, 8'h70, -1, -1);
        blank(5, 1'b0);
        checks++;
        if (wq.size() != 13) begin
            failures++;
            $display("FAIL long_write_count: got %0d required 13", wq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wq[5 + i] !== {1'b1, AW'(i), 8'h70 + 8'(i)}) begin
                    failures++;
                    $display("FAIL long_write[%0d]: got %h required %h", i, wq[5 + i],
                        {1'b1, AW'(i), 8'h70 + 8'(i)});
                end
            end
        end
        checks++;
        if ({err_over, front_bank, fr_cycle.size() == 1} !== 3'b111) begin
            failures++;
            $display("FAIL long_commit: got over=%b front=%b ready=%0d required 1 1 1",
                err_over, front_bank, fr_cycle.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1'b1);
        blank(5, 1'b0); active(NPIX, 8'h11, -1, -1);
        blank(5, 1'b0); active(NPIX, 8'h22, -1, -1);
        blank(5, 1'b1);
        checks++;
        if ({fr_cycle.size() == 2, front_bank, wr_bank} !== 3'b101) begin
            failures++;
            $display("FAIL simul_swap: got ready=%0d front=%b wr=%b required ready=2 front=0 wr=1",
                fr_cycle.size(), front_bank, wr_bank);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(1'b1);
        blank(5, 1'b0); active(NPIX, 8'h33, -1, -1);
        blank(5, 1'b0);
        vsync = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1; pix_in = 8'hC0 + 8'(i);
            step();
            pix_valid = 1'b0;
            if (i < 3) step();
        end
        checks++;
        if ({wr_en, wr_addr, front_bank} !== {1'b1, 4'd3, 1'b1}) begin
            failures++;
            $display("FAIL midreset_pre: got en=%b addr=%0d front=%b required 1 3 1",
                wr_en, wr_addr, front_bank);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({wr_en, wr_addr, wr_bank, front_bank} !== {1'b0, 4'd0, 1'b1, 1'b0}
            || dut.state_reg !== S_WAIT_CFG) begin
            failures++;
            $display("FAIL midreset_post: got en=%b addr=%0d wr=%b front=%b state=%0d required 0 0 1 0 %0d",
                wr_en, wr_addr, wr_bank, front_bank, dut.state_reg, S_WAIT_CFG);
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_continuous();
        test_single_shot();
        test_reader_slow();
        test_short_long();
        test_simultaneous();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_frame_sched.md
Name: cam_frame_sched

Overview:
- Sequences frame capture from the camera pixel path into a two-bank (ping-pong) frame buffer.
- Decides when capture starts (single-shot or continuous) and which bank is written, and generates write enable, address and data.
- Hands completed frames to the display reader with a ready/release handshake, so writer and reader never touch the same bank.
- Sits between the camera capture datapath and the BRAM frame buffer, all in the pclk domain.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- ADDR_W, 19, write-address width; must satisfy 2**ADDR_W >= H_ACT*V_ACT.

Ports:
- pclk  in  1  camera pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- config_done  in  1  sensor register configuration complete; level.
- vsync  in  1  frame sync; high = vertical blanking.
- pix_valid  in  1  one-cycle strobe, one captured pixel available.
- pix_in  in  8  captured pixel byte.
- continuous  in  1  1 = capture every frame; 0 = single-shot.
- start_req  in  1  one-cycle pulse, arms a single-shot capture.
- rd_done  in  1  one-cycle pulse, reader has released the front bank.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  linear pixel address within the bank.
- wr_data  out  8  pixel byte to write.
- wr_bank  out  1  bank currently being written (back bank).
- front_bank  out  1  bank the reader may display.
- frame_ready  out  1  one-cycle pulse when a new frame is committed to the front bank.
- busy  out  1  high in S_SYNC and S_CAPTURE.
- err_short  out  1  sticky; a frame ended before H_ACT*V_ACT pixels.
- err_over  out  1  sticky; a pixel arrived after the last address.

Behaviour:
- Reset values:
  - state S_WAIT_CFG.
  - wr_en=0, wr_addr=0, wr_data=0.
  - wr_bank=1, front_bank=0, front_free=1.
  - frame_ready=0, busy=0, err_short=0, err_over=0.
- Frame-start detection: vsync is registered once into vsync_q; frame start = vsync_q=1 and vsync=0 (falling edge).
- States:
  - S_WAIT_CFG: leave to S_IDLE when config_done=1.
  - S_IDLE: go to S_ARMED if continuous=1, or if start_req=1 (start_req is ignored in every other state).
  - S_ARMED: wait for vsync=1 (blanking), so capture never starts mid-frame; then go to S_SYNC.
  - S_SYNC: on the vsync falling edge, clear the address counter and go to S_CAPTURE.
  - S_CAPTURE:
    - Each pix_valid: wr_en=1, wr_addr=counter, wr_data=pix_in, all registered, visible 1 pclk after pix_valid. The counter then increments.
    - Once the counter reaches H_ACT*V_ACT, further pix_valid produce no write and set err_over.
    - On vsync rising: go to S_COMMIT.
  - S_COMMIT (exactly one cycle):
    - If counter == H_ACT*V_ACT and front_free=1: swap banks (front_bank<=wr_bank, wr_bank<=~wr_bank), front_free<=0, frame_ready=1 for this cycle.
    - If the count is short: set err_short and do not swap.
    - If the count is full but front_free=0: drop the frame, no swap; the back bank is overwritten by the next frame.
    - Next state: S_ARMED if continuous=1, else S_IDLE.
- rd_done sets front_free=1 in any state. If rd_done coincides with S_COMMIT, rd_done is applied first and the swap occurs.
- continuous is sampled only in S_IDLE and S_COMMIT; a change mid-frame takes effect at the next commit.
- config_done falling in any state: go to S_WAIT_CFG; no commit; banks and flags are kept.
- Reset mid-frame: everything returns to reset values; any partial bank contents are don't-care.
- Arithmetic: the address counter is an ADDR_W-bit binary counter and never wraps; it saturates at H_ACT*V_ACT.
- Latency, pix_valid to wr_en: 1 pclk.
- Latency, vsync rise to frame_ready: 2 pclk (vsync register + S_COMMIT).

Optional Feature:
- Macro CAM_SCHED_STATS_EN.
- When defined, add two outputs:
  - frames_committed [15:0]: increments on each frame_ready, wraps at 65535.
  - frames_dropped [15:0]: increments on each full-length frame dropped because front_free=0; saturates at 65535.
  - Both are cleared by reset.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package cam_pkg holds:
  - state enum sched_state_t {S_WAIT_CFG, S_IDLE, S_ARMED, S_SYNC, S_CAPTURE, S_COMMIT};
  - localparams CAM_H_ACT=640 and CAM_V_ACT=480;
  - function frame_pixels(h,v) returning h*v.
- One natural sub-module: cam_bank_swap, which holds wr_bank, front_bank and front_free, with inputs commit_req and rd_done and outputs swap_ok and frame_ready.

Test Plan (bench uses H_ACT=4, V_ACT=2):
1. Continuous, reader always releasing:
   - Stimulus: continuous=1, config_done=1, two frames of 8 pix_valid each.
   - Required response: writes to addresses 0..7 in bank 1, then bank 0; frame_ready pulses twice, 2 pclk after each vsync rise; front_bank sequence 1, 0.
2. Single-shot:
   - Stimulus: continuous=0; start_req mid-frame; then two full frames.
   - Required response: capture begins only after the next vsync high→low; exactly one frame (8 writes) is captured; the second frame produces no wr_en; state returns to S_IDLE.
3. Reader slow:
   - Stimulus: no rd_done after the first commit; a second full frame arrives.
   - Required response: no frame_ready and front_bank unchanged; the third frame, after rd_done, commits into the same back bank (frames_dropped=1 with CAM_SCHED_STATS_EN).
4. Short and long frames:
   - Short: vsync rises after 5 pixels → err_short=1, no swap.
   - Long: 10 pixels → writes only for addresses 0..7, err_over=1, and the frame still commits.
5. Simultaneous and reset:
   - rd_done in the S_COMMIT cycle → swap occurs.
   - Reset asserted at address 3 → next cycle wr_en=0, wr_addr=0, wr_bank=1, front_bank=0, state S_WAIT_CFG.
